// File: rtl/fccc_lock_rst_seq.sv
// LOCK-qualified staged reset sequencer clocked from an FCCC global output.
// Define FCCC_LOCK_TIMEOUT_EN to add the lock-timeout PLL reset request (PLL_ARST_N, TIMEOUT_ERR).
module fccc_lock_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int FILT_CYC    = 256,
  parameter int STAGE_CYC   = 16,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 65536,
  parameter int ARST_CYC    = 32
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              LOCK,
  input  logic              CLR_STAT,
  output logic [NUM_CH-1:0] RST_N_OUT,
  output logic              READY,
  output logic              LOCK_LOST,
  output logic [CNT_W-1:0]  LOSS_CNT,
  output logic              PLL_ARST_N,
  output logic              TIMEOUT_ERR
);

  localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int SW = $clog2(STAGE_CYC + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    PLL_RST   = 3'd4
  } state_t;

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("fccc_lock_rst_seq: NUM_CH must be 1..16");
  end
  if ((FILT_CYC < 2) || (STAGE_CYC < 1) || (CNT_W < 1)) begin : g_bad_timing
    $error("fccc_lock_rst_seq: FILT_CYC >= 2, STAGE_CYC >= 1, CNT_W >= 1 required");
  end
  if ((TIMEOUT_CYC < 1) || (ARST_CYC < 1)) begin : g_bad_timeout
    $error("fccc_lock_rst_seq: TIMEOUT_CYC and ARST_CYC must be >= 1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  state_t            state_q;
  logic              lock_meta_q;
  logic              lock_s_q;
  logic [FW-1:0]     filt_cnt_q;
  logic [SW-1:0]     stage_cnt_q;
  logic [NUM_CH-1:0] rst_n_q;
  logic              ready_q;
  logic              lock_lost_q;
  logic [CNT_W-1:0]  loss_cnt_q;

  logic [NUM_CH-1:0] rst_adv_d;
  logic              loss_d;
  logic              release_d;

`ifdef FCCC_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(ARST_CYC + 1);

  logic [TW-1:0] tmr_q;
  logic [AW-1:0] arst_cnt_q;
  logic          pll_arst_n_q;
  logic          timeout_err_q;
`endif

  // Thermometer advance, loss detection and filter completion for the current cycle.
  always_comb begin
    rst_adv_d = (rst_n_q << 1) | NUM_CH'(1);
    loss_d    = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s_q;
    release_d = (state_q == FILTER) && lock_s_q && (filt_cnt_q == FW'(FILT_CYC - 1));
  end

  // LOCK synchroniser, sequencing FSM, loss statistics and optional timeout.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= WAIT_LOCK;
      filt_cnt_q    <= '0;
      stage_cnt_q   <= '0;
      rst_n_q       <= '0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      loss_cnt_q    <= '0;
`ifdef FCCC_LOCK_TIMEOUT_EN
      tmr_q         <= '0;
      arst_cnt_q    <= '0;
      pll_arst_n_q  <= 1'b1;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;

      // A loss on the same edge as CLR_STAT leaves exactly one recorded loss.
      if (loss_d) begin
        lock_lost_q <= 1'b1;
        loss_cnt_q  <= CLR_STAT ? CNT_W'(1) : sat_inc(loss_cnt_q);
      end else if (CLR_STAT) begin
        lock_lost_q <= 1'b0;
        loss_cnt_q  <= '0;
      end else begin
        lock_lost_q <= lock_lost_q;
        loss_cnt_q  <= loss_cnt_q;
      end

      case (state_q)
        WAIT_LOCK: begin
          rst_n_q <= '0;
          ready_q <= 1'b0;
          if (lock_s_q) begin
            state_q    <= FILTER;
            filt_cnt_q <= '0;
          end
        end
        FILTER: begin
          if (!lock_s_q) begin
            state_q <= WAIT_LOCK;
          end else if (release_d) begin
            rst_n_q     <= NUM_CH'(1);
            stage_cnt_q <= '0;
            if (NUM_CH == 1) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
          end
        end
        RELEASE: begin
          if (loss_d) begin
            rst_n_q <= '0;
            ready_q <= 1'b0;
            state_q <= WAIT_LOCK;
          end else if (stage_cnt_q == SW'(STAGE_CYC - 1)) begin
            stage_cnt_q <= '0;
            rst_n_q     <= rst_adv_d;
            if (&rst_adv_d) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end
          end else begin
            stage_cnt_q <= stage_cnt_q + SW'(1);
          end
        end
        RUN: begin
          if (loss_d) begin
            rst_n_q <= '0;
            ready_q <= 1'b0;
            state_q <= WAIT_LOCK;
          end
        end
`ifdef FCCC_LOCK_TIMEOUT_EN
        PLL_RST: begin
          rst_n_q <= '0;
          ready_q <= 1'b0;
          if (arst_cnt_q == AW'(ARST_CYC - 1)) begin
            pll_arst_n_q <= 1'b1;
            tmr_q        <= '0;
            state_q      <= WAIT_LOCK;
          end else begin
            arst_cnt_q <= arst_cnt_q + AW'(1);
          end
        end
`endif
        default: begin
          rst_n_q <= '0;
          ready_q <= 1'b0;
          state_q <= WAIT_LOCK;
        end
      endcase

`ifdef FCCC_LOCK_TIMEOUT_EN
      if (CLR_STAT) begin
        timeout_err_q <= 1'b0;
      end
      // Timeout takes priority over a release landing on the same edge.
      if ((state_q == WAIT_LOCK) || (state_q == FILTER)) begin
        if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q       <= PLL_RST;
          rst_n_q       <= '0;
          ready_q       <= 1'b0;
          pll_arst_n_q  <= 1'b0;
          timeout_err_q <= 1'b1;
          arst_cnt_q    <= '0;
          tmr_q         <= '0;
        end else if (release_d) begin
          tmr_q <= '0;
        end else begin
          tmr_q <= tmr_q + TW'(1);
        end
      end
`endif
    end
  end

  assign RST_N_OUT = rst_n_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lock_lost_q;
  assign LOSS_CNT  = loss_cnt_q;
`ifdef FCCC_LOCK_TIMEOUT_EN
  assign PLL_ARST_N  = pll_arst_n_q;
  assign TIMEOUT_ERR = timeout_err_q;
`else
  assign PLL_ARST_N  = 1'b1;
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fccc_lock_rst_seq.sv
// Randomised bench for fccc_lock_rst_seq against a run-length reference model.
module tb_fccc_lock_rst_seq;

  localparam int N  = 4;
  localparam int F  = 8;
  localparam int S  = 4;
  localparam int CW = 2;
  localparam int T  = 64;
  localparam int A  = 4;

  logic          pclk     = 1'b0;
  logic          preset_n = 1'b0;
  logic          lock     = 1'b0;
  logic          clr      = 1'b0;
  logic [N-1:0]  rst_n_out;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] loss_cnt;
  logic          pll_arst_n;
  logic          timeout_err;

  fccc_lock_rst_seq #(
    .NUM_CH(N), .FILT_CYC(F), .STAGE_CYC(S), .CNT_W(CW),
    .TIMEOUT_CYC(T), .ARST_CYC(A)
  ) dut (
    .PCLK(pclk), .PRESET_N(preset_n), .LOCK(lock), .CLR_STAT(clr),
    .RST_N_OUT(rst_n_out), .READY(ready), .LOCK_LOST(lock_lost),
    .LOSS_CNT(loss_cnt), .PLL_ARST_N(pll_arst_n), .TIMEOUT_ERR(timeout_err)
  );

  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: lock_s is LOCK delayed by two edges; release depends on the run
  // of consecutive lock_s-high edges.
  logic hist[2];
  int   run, rel, unq, pll_left, m_cnt;
  logic m_lost, m_terr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    hist[0] = 1'b0; hist[1] = 1'b0;
    run = 0; rel = 0; unq = 0; pll_left = 0; m_cnt = 0;
    m_lost = 1'b0; m_terr = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic c);
    logic ls;
    logic loss;
    ls = hist[1];
    hist[1] = hist[0];
    hist[0] = l;
    loss = (rel > 0) && !ls;
    if (c) m_terr = 1'b0;
    if (pll_left > 0) begin
      pll_left--;
      if (pll_left == 0) begin
        run = 0;
        unq = 0;
      end
    end else if (rel > 0) begin
      if (!ls) begin
        rel = 0;
        run = 0;
      end else begin
        run++;
        rel = 1 + (run - F - 1) / S;
        if (rel > N) rel = N;
      end
    end else begin
`ifdef FCCC_LOCK_TIMEOUT_EN
      if (unq == T - 1) begin
        pll_left = A;
        m_terr   = 1'b1;
        run      = 0;
        unq      = 0;
      end else
`endif
      begin
        run = ls ? run + 1 : 0;
        if (run == F + 1) begin
          rel = 1;
          unq = 0;
        end else begin
          unq++;
        end
      end
    end
    if (loss) begin
      m_lost = 1'b1;
      m_cnt  = c ? 1 : ((m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt);
    end else if (c) begin
      m_lost = 1'b0;
      m_cnt  = 0;
    end
  endtask

  task automatic check_all();
    chk("rst_n_out",   32'(rst_n_out),   32'((1 << rel) - 1));
    chk("ready",       32'(ready),       32'(rel == N));
    chk("lock_lost",   32'(lock_lost),   32'(m_lost));
    chk("loss_cnt",    32'(loss_cnt),    32'(m_cnt));
    chk("pll_arst_n",  32'(pll_arst_n),  32'(pll_left == 0));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic step(input logic l, input logic c);
    lock = l;
    clr  = c;
    @(posedge pclk);
    model_edge(l, c);
    @(negedge pclk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge pclk);
    check_all();
    preset_n = 1'b1;

    // Clean lock: full staged release and RUN.
    repeat (30) step(1'b1, 1'b0);

    // One-cycle dropout while filtering.
    repeat (10) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);

    // Losses from RUN until the counter saturates, then clear.
    for (int k = 0; k < 4; k++) begin
      repeat (3) step(1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0);
    end
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);

    // CLR_STAT on the loss edge (two edges after LOCK is sampled low).
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (30) step(1'b1, 1'b0);

    // Asynchronous reset part-way through the release.
    repeat (3) step(1'b0, 1'b0);
    begin : wait_two
      int guard;
      guard = 0;
      while ((rel != 2) && (guard < 200)) begin
        step(1'b1, 1'b0);
        guard++;
      end
      chk("reach_0011", 32'(rst_n_out), 32'h3);
    end
    #2;
    preset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge pclk);
    check_all();
    preset_n = 1'b1;
    repeat (30) step(1'b1, 1'b0);

    // Long lock absence: exercises the timeout path when it is built in.
    repeat (150) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0);

    // Randomised lock bursts with sporadic status clears.
    for (int k = 0; k < 60; k++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(40, 1));
      lo = int'($urandom_range(8, 1));
      for (int j = 0; j < hi; j++) step(1'b1, ($urandom_range(15, 0) == 0));
      for (int j = 0; j < lo; j++) step(1'b0, ($urandom_range(15, 0) == 0));
    end
    repeat (30) step(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
